// File: rtl/ypbpr2rgb_conv_if.sv
// ypbpr2rgb_conv_if: pixel bus carrying a qualifier and a {S, V1, V2, V3} word
interface ypbpr2rgb_conv_if #(
  parameter int W = 28
);
  logic         valid;
  logic [W-1:0] data;
  modport master(output valid, data);
  modport slave(input valid, data);
endinterface

// File: rtl/ypbpr2rgb_conv.sv
// ypbpr2rgb_conv: 4-stage Rec.601 YPbPr->RGB converter with per-pixel bypass.
// Define YPBPR2RGB_CLIPCNT_EN to build the saturating clipped-pixel counter.
module ypbpr2rgb_conv #(
  parameter int COLOR_W = 8,
  parameter int CFRAC   = 18
) (
  input  logic                   VCLK,
  input  logic                   RST,
  input  logic                   nEN_RGB,
  ypbpr2rgb_conv_if.slave        vdata_i,
  ypbpr2rgb_conv_if.master       vdata_o,
  input  logic                   clip_clr,
  output logic [15:0]            clip_cnt
);
  localparam int W  = COLOR_W;
  localparam int DW = 4 + 3 * W;
  localparam int P  = W + CFRAC + 2;
  localparam int S  = P + 1;
  localparam logic signed [W:0]   HALF  = (W + 1)'(1 << (W - 1));
  localparam logic signed [P-1:0] K_RPR = P'(367526);
  localparam logic signed [P-1:0] K_GPB = P'(90213);
  localparam logic signed [P-1:0] K_GPR = P'(187206);
  localparam logic signed [P-1:0] K_BPB = P'(464519);
  localparam logic signed [S-1:0] RND   = S'(1 << (CFRAC - 1));
  localparam logic signed [S-1:0] MAXV  = S'((1 << W) - 1);

  logic [DW-1:0]         w0_q, w1_q, w2_q, out_q, out_d;
  logic                  v0_q, v1_q, v2_q, vout_q;
  logic                  m0_q, m1_q, m2_q;
  logic signed [W:0]     pb0_q, pr0_q, pb0_d, pr0_d;
  logic signed [P-1:0]   rpr1_q, gpb1_q, gpr1_q, bpb1_q;
  logic signed [S-1:0]   rs2_q, gs2_q, bs2_q, rs_d, gs_d, bs_d, yx1;
  logic [W:0]            cr, cg, cb;
  logic                  clip_ev;

  // {clipped, value}: round-half-up already folded into the sum, so floor here
  function automatic logic [W:0] clamp(input logic signed [S-1:0] v);
    logic signed [S-1:0] t;
    t = v >>> CFRAC;
    return t[S-1] ? {1'b1, {W{1'b0}}} : (t > MAXV) ? {1'b1, {W{1'b1}}} : {1'b0, t[W-1:0]};
  endfunction

  always_comb begin
    pb0_d   = $signed({1'b0, vdata_i.data[W-1:0]}) - HALF;
    pr0_d   = $signed({1'b0, vdata_i.data[3*W-1:2*W]}) - HALF;
    yx1     = S'({1'b0, w1_q[2*W-1:W], {CFRAC{1'b0}}});
    rs_d    = yx1 + S'(rpr1_q) + RND;
    gs_d    = yx1 - S'(gpb1_q) - S'(gpr1_q) + RND;
    bs_d    = yx1 + S'(bpb1_q) + RND;
    cr      = clamp(rs2_q);
    cg      = clamp(gs2_q);
    cb      = clamp(bs2_q);
    out_d   = m2_q ? w2_q : {w2_q[DW-1-:4], cr[W-1:0], cg[W-1:0], cb[W-1:0]};
    clip_ev = v2_q & ~m2_q & (cr[W] | cg[W] | cb[W]);
  end

  // The raw word and mode ride along every stage so bypass and sync match the datapath latency
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      w0_q   <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      out_q  <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      vout_q <= 1'b0;
      m0_q   <= 1'b0;
      m1_q   <= 1'b0;
      m2_q   <= 1'b0;
      pb0_q  <= '0;
      pr0_q  <= '0;
      rpr1_q <= '0;
      gpb1_q <= '0;
      gpr1_q <= '0;
      bpb1_q <= '0;
      rs2_q  <= '0;
      gs2_q  <= '0;
      bs2_q  <= '0;
    end else begin
      w0_q   <= vdata_i.data;
      v0_q   <= vdata_i.valid;
      m0_q   <= nEN_RGB;
      pb0_q  <= pb0_d;
      pr0_q  <= pr0_d;
      w1_q   <= w0_q;
      v1_q   <= v0_q;
      m1_q   <= m0_q;
      rpr1_q <= K_RPR * P'(pr0_q);
      gpb1_q <= K_GPB * P'(pb0_q);
      gpr1_q <= K_GPR * P'(pr0_q);
      bpb1_q <= K_BPB * P'(pb0_q);
      w2_q   <= w1_q;
      v2_q   <= v1_q;
      m2_q   <= m1_q;
      rs2_q  <= rs_d;
      gs2_q  <= gs_d;
      bs2_q  <= bs_d;
      out_q  <= out_d;
      vout_q <= v2_q;
    end
  end

  assign vdata_o.valid = vout_q;
  assign vdata_o.data  = out_q;

`ifdef YPBPR2RGB_CLIPCNT_EN
  logic [15:0] cnt_q, cnt_d;
  // Clear wins over a coincident clip event
  always_comb cnt_d = clip_clr ? 16'h0000 : (clip_ev && cnt_q != 16'hFFFF) ? cnt_q + 16'h0001 : cnt_q;
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) cnt_q <= 16'h0000;
    else cnt_q <= cnt_d;
  end
  assign clip_cnt = cnt_q;
`else
  logic unused_clip;
  assign unused_clip = clip_clr ^ clip_ev;
  assign clip_cnt    = 16'h0000;
`endif
endmodule

// File: tb/tb_ypbpr2rgb_conv.sv
// tb_ypbpr2rgb_conv: randomized and directed checks of ypbpr2rgb_conv against an integer reference model
module tb_ypbpr2rgb_conv;
  logic        VCLK = 1'b0;
  logic        RST;
  logic        nEN_RGB;
  logic        clip_clr;
  logic [15:0] clip_cnt;
  int          pass_cnt = 0;
  int          total = 0;
  int          n = 0;
  int          cnt_exp = 0;
  logic        hv[8];
  logic        hc[8];
  logic [27:0] hw[8];
  logic        ev;
  logic [27:0] ew;

  ypbpr2rgb_conv_if #(.W(28)) vin ();
  ypbpr2rgb_conv_if #(.W(28)) vout ();

  ypbpr2rgb_conv dut (
    .VCLK(VCLK), .RST(RST), .nEN_RGB(nEN_RGB),
    .vdata_i(vin), .vdata_o(vout),
    .clip_clr(clip_clr), .clip_cnt(clip_cnt)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int fdiv(input int x);
    return (x >= 0) ? x / 262144 : -((-x + 262143) / 262144);
  endfunction

  // Rec.601 inverse with real-valued coefficients quantised to 2^-18, round-half-up, clamp
  function automatic logic [27:0] model(input logic m, input logic [27:0] w, output logic clip);
    int y, pb, pr;
    int c[3];
    y    = int'(w[15:8]);
    pb   = int'(w[7:0]) - 128;
    pr   = int'(w[23:16]) - 128;
    c[0] = fdiv(y * 262144 + 367526 * pr + 131072);
    c[1] = fdiv(y * 262144 - 90213 * pb - 187206 * pr + 131072);
    c[2] = fdiv(y * 262144 + 464519 * pb + 131072);
    clip = 1'b0;
    for (int i = 0; i < 3; i++)
      if (c[i] < 0 || c[i] > 255) begin
        clip = 1'b1;
        c[i] = (c[i] < 0) ? 0 : 255;
      end
    return m ? w : {w[27:24], 8'(c[0]), 8'(c[1]), 8'(c[2])};
  endfunction

  task automatic clear_ring();
    for (int i = 0; i < 8; i++) begin
      hv[i] = 1'b0;
      hc[i] = 1'b0;
      hw[i] = '0;
    end
    cnt_exp = 0;
  endtask

  // Drive one pixel for one clock; afterwards ev/ew hold what must be on the output now
  task automatic step(input logic v, input logic m, input logic [27:0] w, input logic clr);
    logic        c;
    logic [27:0] e;
    int          k;
    vin.valid = v;
    vin.data  = w;
    nEN_RGB   = m;
    clip_clr  = clr;
    e = model(m, w, c);
    @(posedge VCLK);
    n++;
    hv[n % 8] = v;
    hw[n % 8] = e;
    hc[n % 8] = c & ~m;
    k = (n + 5) % 8;
`ifdef YPBPR2RGB_CLIPCNT_EN
    if (clr) cnt_exp = 0;
    else if (hv[k] && hc[k] && cnt_exp != 65535) cnt_exp++;
`endif
    ev = hv[k];
    ew = hw[k];
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    vin.valid = 1'b1;
    vin.data = 28'($urandom);
    nEN_RGB = 1'b0;
    clip_clr = 1'b0;
    repeat (3) @(posedge VCLK);
    #1;
    total++; if (vout.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", vout.valid); else pass_cnt++;
    total++; if (vout.data !== 28'h0) $display("FAIL reset_data: got %h want 0", vout.data); else pass_cnt++;
    total++; if (clip_cnt !== 16'h0) $display("FAIL reset_cnt: got %h want 0", clip_cnt); else pass_cnt++;
    RST = 1'b0;
    clear_ring();
  endtask

  task automatic test_neutral();
    int c0;
    repeat (4) step(1'b0, 1'b0, 28'h0, 1'b0);
    c0 = cnt_exp;
    step(1'b1, 1'b0, {4'h0, 8'd128, 8'd128, 8'd128}, 1'b0);
    for (int i = 1; i < 4; i++) begin
      total++; if (vout.valid !== 1'b0) $display("FAIL neutral_early_valid: step %0d got %b want 0", i, vout.valid); else pass_cnt++;
      step(1'b0, 1'b0, 28'h0, 1'b0);
    end
    total++; if (vout.valid !== 1'b1) $display("FAIL neutral_valid: got %b want 1", vout.valid); else pass_cnt++;
    total++; if (vout.data !== {4'h0, 8'd128, 8'd128, 8'd128}) $display("FAIL neutral_data: got %h want 0808080", vout.data); else pass_cnt++;
    total++; if (int'(clip_cnt) !== c0) $display("FAIL neutral_cnt: got %0d want %0d", clip_cnt, c0); else pass_cnt++;
  endtask

  task automatic test_upper_clip();
    int c0;
    c0 = cnt_exp;
    step(1'b1, 1'b0, {4'h0, 8'd255, 8'd255, 8'd128}, 1'b0);
    repeat (3) step(1'b0, 1'b0, 28'h0, 1'b0);
    total++; if (vout.data !== {4'h0, 8'd255, 8'd164, 8'd255}) $display("FAIL upper_data: got %h want 0ffa4ff", vout.data); else pass_cnt++;
`ifdef YPBPR2RGB_CLIPCNT_EN
    total++; if (int'(clip_cnt) !== c0 + 1) $display("FAIL upper_cnt: got %0d want %0d", clip_cnt, c0 + 1); else pass_cnt++;
`else
    total++; if (clip_cnt !== 16'h0) $display("FAIL upper_cnt: got %0d want 0", clip_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_lower_clip();
    step(1'b1, 1'b0, {4'h5, 8'd0, 8'd0, 8'd0}, 1'b0);
    repeat (3) step(1'b0, 1'b0, 28'h0, 1'b0);
    total++; if (vout.valid !== 1'b1) $display("FAIL lower_valid: got %b want 1", vout.valid); else pass_cnt++;
    total++; if (vout.data !== {4'h5, 8'd0, 8'd135, 8'd0}) $display("FAIL lower_data: got %h want 5008700", vout.data); else pass_cnt++;
    total++; if (int'(clip_cnt) !== cnt_exp) $display("FAIL lower_cnt: got %0d want %0d", clip_cnt, cnt_exp); else pass_cnt++;
  endtask

  task automatic test_bypass();
    int c0;
    c0 = cnt_exp;
    step(1'b1, 1'b1, {4'hA, 8'h12, 8'h34, 8'h56}, 1'b0);
    repeat (3) step(1'b0, 1'b1, 28'h0, 1'b0);
    total++; if (vout.data !== 28'hA123456) $display("FAIL bypass_data: got %h want a123456", vout.data); else pass_cnt++;
    total++; if (vout.valid !== 1'b1) $display("FAIL bypass_valid: got %b want 1", vout.valid); else pass_cnt++;
    // A bypassed clipping-range word must not count
    step(1'b1, 1'b1, {4'h0, 8'd255, 8'd255, 8'd128}, 1'b0);
    repeat (3) step(1'b0, 1'b1, 28'h0, 1'b0);
    total++; if (int'(clip_cnt) !== c0) $display("FAIL bypass_cnt: got %0d want %0d", clip_cnt, c0); else pass_cnt++;
  endtask

  task automatic test_mode_toggle();
    logic [7:0] r;
    for (int i = 0; i < 23; i++) begin
      r = 8'(i * 11);
      if (i < 20) step(1'b1, i[0], {r[3:0], r, 8'(r + 8'd40), 8'(8'd255 - r)}, 1'b0);
      else step(1'b0, 1'b0, 28'h0, 1'b0);
      total++; if (vout.valid !== ev || vout.data !== ew) $display("FAIL mode_toggle: step %0d got %b/%h want %b/%h", i, vout.valid, vout.data, ev, ew); else pass_cnt++;
    end
  endtask

  task automatic test_valid_bubbles();
    for (int i = 0; i < 24; i++) begin
      step(i[0], 1'b0, 28'($urandom), 1'b0);
      total++; if (vout.valid !== ev) $display("FAIL bubble_valid: step %0d got %b want %b", i, vout.valid, ev); else pass_cnt++;
      total++; if (vout.data !== ew) $display("FAIL bubble_data: step %0d got %h want %h", i, vout.data, ew); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), ($urandom % 4) == 0, 28'($urandom), ($urandom % 40) == 0);
      total++; if (vout.valid !== ev || vout.data !== ew) $display("FAIL random_out: step %0d got %b/%h want %b/%h", i, vout.valid, vout.data, ev, ew); else pass_cnt++;
      total++; if (int'(clip_cnt) !== cnt_exp) $display("FAIL random_cnt: step %0d got %0d want %0d", i, clip_cnt, cnt_exp); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream();
    repeat (6) step(1'b1, 1'b0, {4'h0, 8'd255, 8'd255, 8'd128}, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    total++; if (vout.valid !== 1'b0 || vout.data !== 28'h0) $display("FAIL midreset_out: got %b/%h want 0/0", vout.valid, vout.data); else pass_cnt++;
    total++; if (clip_cnt !== 16'h0) $display("FAIL midreset_cnt: got %0d want 0", clip_cnt); else pass_cnt++;
    @(posedge VCLK);
    #1;
    RST = 1'b0;
    clear_ring();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 28'($urandom), 1'b0);
      total++; if (vout.valid !== 1'b0) $display("FAIL midreset_stale: step %0d got %b want 0", i, vout.valid); else pass_cnt++;
    end
    step(1'b1, 1'b0, {4'h3, 8'd128, 8'd128, 8'd128}, 1'b0);
    repeat (3) step(1'b0, 1'b0, 28'h0, 1'b0);
    total++; if (vout.valid !== 1'b1 || vout.data !== {4'h3, 8'd128, 8'd128, 8'd128}) $display("FAIL midreset_first: got %b/%h want 1/3808080", vout.valid, vout.data); else pass_cnt++;
  endtask

`ifdef YPBPR2RGB_CLIPCNT_EN
  task automatic test_counter();
    logic [27:0] up;
    up = {4'h0, 8'd255, 8'd255, 8'd128};
    step(1'b0, 1'b0, 28'h0, 1'b1);
    repeat (65540) step(1'b1, 1'b0, up, 1'b0);
    repeat (3) step(1'b0, 1'b0, 28'h0, 1'b0);
    total++; if (clip_cnt !== 16'hFFFF) $display("FAIL cnt_saturate: got %h want ffff", clip_cnt); else pass_cnt++;
    step(1'b0, 1'b0, 28'h0, 1'b1);
    step(1'b1, 1'b0, up, 1'b0);
    repeat (3) step(1'b0, 1'b0, 28'h0, 1'b0);
    total++; if (clip_cnt !== 16'h1) $display("FAIL cnt_after_clear: got %h want 1", clip_cnt); else pass_cnt++;
    step(1'b1, 1'b0, up, 1'b0);
    repeat (2) step(1'b0, 1'b0, 28'h0, 1'b0);
    step(1'b0, 1'b0, 28'h0, 1'b1);
    total++; if (clip_cnt !== 16'h0) $display("FAIL cnt_clear_wins: got %h want 0", clip_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    clear_ring();
    test_reset();
    test_neutral();
    test_upper_clip();
    test_lower_clip();
    test_bypass();
    test_mode_toggle();
    test_valid_bubbles();
    test_random();
    test_reset_midstream();
`ifdef YPBPR2RGB_CLIPCNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
